// File: rtl/counter_binary.sv
// Loadable up/down binary counter stepping by a fixed increment; clear beats load beats run.
module counter_binary #(
  parameter int unsigned            WORD_WIDTH    = 8,
  parameter logic [WORD_WIDTH-1:0]  INCREMENT     = WORD_WIDTH'(1),
  parameter logic [WORD_WIDTH-1:0]  INITIAL_COUNT = '0
) (
  input  logic                  clock,
  input  logic                  areset,
  input  logic                  clear,
  input  logic                  up_down,
  input  logic                  run,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_count,
  input  logic                  carry_in,
  output logic [WORD_WIDTH-1:0] count,
  output logic                  carry_out
);

  logic [WORD_WIDTH:0] step_c;

  // up_down=1 counts down; the extra bit is the carry or borrow.
  always_comb begin
    if (up_down) begin
      step_c = {1'b0, count} - {1'b0, INCREMENT} - (WORD_WIDTH+1)'(carry_in);
    end else begin
      step_c = {1'b0, count} + {1'b0, INCREMENT} + (WORD_WIDTH+1)'(carry_in);
    end
  end

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      count     <= INITIAL_COUNT;
      carry_out <= 1'b0;
    end else if (clear) begin
      count     <= INITIAL_COUNT;
      carry_out <= 1'b0;
    end else if (load) begin
      count     <= load_count;
      carry_out <= 1'b0;
    end else if (run) begin
      count     <= step_c[WORD_WIDTH-1:0];
      carry_out <= step_c[WORD_WIDTH];
    end
  end

endmodule

// File: rtl/register.sv
// Generic enabled register with asynchronous reset and synchronous clear.
module register #(
  parameter int unsigned            WORD_WIDTH  = 1,
  parameter logic [WORD_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  areset,
  input  logic                  clock_enable,
  input  logic                  clear,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out
);

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      data_out <= RESET_VALUE;
    end else if (clear) begin
      data_out <= RESET_VALUE;
    end else if (clock_enable) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/burst_sequencer.sv
// Expands one {address, length, direction} command into a stream of strided
// address beats over valid/ready handshakes.
module burst_sequencer #(
  parameter int unsigned            ADDR_WIDTH   = 8,
  parameter int unsigned            LENGTH_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]  STRIDE       = ADDR_WIDTH'(1)
) (
  input  logic                    clock,
  input  logic                    areset,
  input  logic                    clear,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_address,
  input  logic [LENGTH_WIDTH-1:0] cmd_length,
  input  logic                    cmd_down,
  output logic                    beat_valid,
  input  logic                    beat_ready,
  output logic [ADDR_WIDTH-1:0]   beat_address,
  output logic                    beat_last,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [LENGTH_WIDTH-1:0] BEAT_STEP = LENGTH_WIDTH'(1);

  state_t                  state;
  state_t                  state_next;
  logic                    state_bit;
  logic                    done_next;
  logic                    down_latched;
  logic                    cmd_accept;
  logic                    beat_handshake;
  logic [LENGTH_WIDTH-1:0] remaining;
  logic                    addr_carry_unused;
  logic                    remaining_carry_unused;

  assign state = state_t'(state_bit);

  // Handshake-facing flags decode only from registered state and counters.
  assign cmd_ready      = (state == IDLE);
  assign beat_valid     = (state == RUN);
  assign busy           = (state == RUN);
  assign beat_last      = (state == RUN) && (remaining == BEAT_STEP);
  assign cmd_accept     = cmd_valid && cmd_ready;
  assign beat_handshake = beat_valid && beat_ready;

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_accept) begin
          if (cmd_length != '0) begin
            state_next = RUN;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (beat_handshake && beat_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
    endcase
  end

  register #(.WORD_WIDTH(1), .RESET_VALUE(1'b0)) u_state_reg (
    .clock        (clock),
    .areset       (areset),
    .clock_enable (1'b1),
    .clear        (clear),
    .data_in      (state_next),
    .data_out     (state_bit)
  );

  register #(.WORD_WIDTH(1), .RESET_VALUE(1'b0)) u_done_reg (
    .clock        (clock),
    .areset       (areset),
    .clock_enable (1'b1),
    .clear        (clear),
    .data_in      (done_next),
    .data_out     (done)
  );

  // Direction is held for the whole burst; command fields may change after accept.
  register #(.WORD_WIDTH(1), .RESET_VALUE(1'b0)) u_down_reg (
    .clock        (clock),
    .areset       (areset),
    .clock_enable (cmd_accept),
    .clear        (clear),
    .data_in      (cmd_down),
    .data_out     (down_latched)
  );

  counter_binary #(
    .WORD_WIDTH    (ADDR_WIDTH),
    .INCREMENT     (STRIDE),
    .INITIAL_COUNT ('0)
  ) u_addr_counter (
    .clock      (clock),
    .areset     (areset),
    .clear      (clear),
    .up_down    (down_latched),
    .run        (beat_handshake),
    .load       (cmd_accept),
    .load_count (cmd_address),
    .carry_in   (1'b0),
    .count      (beat_address),
    .carry_out  (addr_carry_unused)
  );

  counter_binary #(
    .WORD_WIDTH    (LENGTH_WIDTH),
    .INCREMENT     (BEAT_STEP),
    .INITIAL_COUNT ('0)
  ) u_remaining_counter (
    .clock      (clock),
    .areset     (areset),
    .clear      (clear),
    .up_down    (1'b1),
    .run        (beat_handshake),
    .load       (cmd_accept),
    .load_count (cmd_length),
    .carry_in   (1'b0),
    .count      (remaining),
    .carry_out  (remaining_carry_unused)
  );

endmodule

// File: tb/tb_burst_sequencer.sv
// Self-checking bench for burst_sequencer: directed vector table, hand-written
// abort/reset sequences, then random traffic against a beat-queue model.
module tb_burst_sequencer;

  localparam int unsigned AW     = 8;
  localparam int unsigned LW     = 4;
  localparam logic [7:0]  STRIDE = 8'd4;

  logic          clock;
  logic          areset;
  logic          clear;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_address;
  logic [LW-1:0] cmd_length;
  logic          cmd_down;
  logic          beat_valid;
  logic          beat_ready;
  logic [AW-1:0] beat_address;
  logic          beat_last;
  logic          busy;
  logic          done;

  int checks;
  int errors;

  burst_sequencer #(.ADDR_WIDTH(AW), .LENGTH_WIDTH(LW), .STRIDE(STRIDE)) dut (
    .clock        (clock),
    .areset       (areset),
    .clear        (clear),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_address  (cmd_address),
    .cmd_length   (cmd_length),
    .cmd_down     (cmd_down),
    .beat_valid   (beat_valid),
    .beat_ready   (beat_ready),
    .beat_address (beat_address),
    .beat_last    (beat_last),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       cv;
    logic [7:0] ca;
    logic [3:0] cl;
    logic       cd;
    logic       br;
    logic       e_bv;
    logic [7:0] e_ad;
    logic       e_last;
    logic       e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic cv, input logic [7:0] ca, input logic [3:0] cl,
                              input logic cd, input logic br, input logic e_bv,
                              input logic [7:0] e_ad, input logic e_last, input logic e_done);
    vec_t v;
    v.cv = cv; v.ca = ca; v.cl = cl; v.cd = cd; v.br = br;
    v.e_bv = e_bv; v.e_ad = e_ad; v.e_last = e_last; v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " cmd_ready"},    32'(cmd_ready),    32'd1);
    chk({tag, " beat_valid"},   32'(beat_valid),   32'd0);
    chk({tag, " beat_address"}, 32'(beat_address), 32'd0);
    chk({tag, " beat_last"},    32'(beat_last),    32'd0);
    chk({tag, " busy"},         32'(busy),         32'd0);
    chk({tag, " done"},         32'(done),         32'd0);
  endtask

  task automatic drive_cmd(input logic cv, input logic [7:0] ca, input logic [3:0] cl,
                           input logic cd);
    cmd_valid = cv; cmd_address = ca; cmd_length = cl; cmd_down = cd;
  endtask

  logic [7:0] mq[$];
  bit         mdone;

  initial begin
    checks = 0;
    errors = 0;
    areset = 1'b1;
    clear  = 1'b0;
    beat_ready = 1'b0;
    drive_cmd(1'b0, 8'h00, 4'd0, 1'b0);

    // Reset values, during and after reset.
    repeat (2) @(posedge clock);
    #1;
    chk_reset_values("in_reset");
    areset = 1'b0;
    tick();
    chk_reset_values("after_reset");

    // Basic burst
    tbl.push_back(mk(1, 8'h10, 3, 0, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h10, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h14, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h18, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
    // Backpressure 1,0,0,1,1
    tbl.push_back(mk(1, 8'h10, 3, 0, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h10, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'h14, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'h14, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h14, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h18, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
    // Descending wrap
    tbl.push_back(mk(1, 8'h04, 3, 1, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h04, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'hFC, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
    // Zero length, then a length-1 command accepted alongside its done
    tbl.push_back(mk(1, 8'h55, 0, 0, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h33, 1, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h33, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0));

    foreach (tbl[i]) begin
      drive_cmd(tbl[i].cv, tbl[i].ca, tbl[i].cl, tbl[i].cd);
      beat_ready = tbl[i].br;
      chk($sformatf("vec%0d beat_valid", i), 32'(beat_valid), 32'(tbl[i].e_bv));
      chk($sformatf("vec%0d cmd_ready", i),  32'(cmd_ready),  32'(!tbl[i].e_bv));
      chk($sformatf("vec%0d busy", i),       32'(busy),       32'(tbl[i].e_bv));
      chk($sformatf("vec%0d done", i),       32'(done),       32'(tbl[i].e_done));
      chk($sformatf("vec%0d beat_last", i),  32'(beat_last),  32'(tbl[i].e_last));
      if (tbl[i].e_bv) begin
        chk($sformatf("vec%0d beat_address", i), 32'(beat_address), 32'(tbl[i].e_ad));
      end
      tick();
    end

    // Abort during the 2nd beat of a 5-beat burst
    drive_cmd(1'b1, 8'h20, 4'd5, 1'b0);
    beat_ready = 1'b1;
    tick();
    drive_cmd(1'b0, 8'h00, 4'd0, 1'b0);
    chk("abort beat1", 32'(beat_address), 32'h20);
    tick();
    chk("abort beat2", 32'(beat_address), 32'h24);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_reset_values("after_clear");
    for (int k = 0; k < 3; k++) begin
      chk("abort no done", 32'(done), 32'd0);
      tick();
    end
    drive_cmd(1'b1, 8'h40, 4'd2, 1'b0);
    chk("post_abort cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    drive_cmd(1'b0, 8'h00, 4'd0, 1'b0);
    chk("post_abort beat1", 32'(beat_address), 32'h40);
    chk("post_abort last1", 32'(beat_last), 32'd0);
    tick();
    chk("post_abort beat2", 32'(beat_address), 32'h44);
    chk("post_abort last2", 32'(beat_last), 32'd1);
    tick();
    chk("post_abort done", 32'(done), 32'd1);
    chk("post_abort idle", 32'(beat_valid), 32'd0);
    tick();

    // Asynchronous reset in the middle of a burst
    drive_cmd(1'b1, 8'h80, 4'd5, 1'b0);
    tick();
    drive_cmd(1'b0, 8'h00, 4'd0, 1'b0);
    chk("rst_mid beat1", 32'(beat_address), 32'h80);
    tick();
    areset = 1'b1;
    #1;
    chk_reset_values("async_reset");
    @(posedge clock);
    #1;
    chk_reset_values("held_reset");
    areset = 1'b0;
    tick();
    chk_reset_values("released_reset");

    // Random traffic against a queue of expected beat addresses
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mq.delete();
    mdone = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [7:0] a;
      logic [3:0] len;
      bit         nd;
      case ($urandom_range(0, 3))
        0:       len = 4'd0;
        1:       len = 4'd1;
        2:       len = 4'd15;
        default: len = 4'($urandom_range(0, 15));
      endcase
      drive_cmd(1'($urandom_range(0, 1)), 8'($urandom), len, 1'($urandom_range(0, 1)));
      beat_ready = ($urandom_range(0, 9) < 7);
      clear      = ($urandom_range(0, 99) < 2);

      chk($sformatf("rnd%0d beat_valid", cyc), 32'(beat_valid), 32'(mq.size() != 0));
      chk($sformatf("rnd%0d cmd_ready", cyc),  32'(cmd_ready),  32'(mq.size() == 0));
      chk($sformatf("rnd%0d done", cyc),       32'(done),       32'(mdone));
      if (mq.size() != 0) begin
        chk($sformatf("rnd%0d beat_address", cyc), 32'(beat_address), 32'(mq[0]));
        chk($sformatf("rnd%0d beat_last", cyc),    32'(beat_last),    32'(mq.size() == 1));
      end else begin
        chk($sformatf("rnd%0d beat_last", cyc), 32'(beat_last), 32'd0);
      end

      if (clear) begin
        mq.delete();
        mdone = 1'b0;
      end else begin
        nd = 1'b0;
        if (mq.size() == 0) begin
          if (cmd_valid) begin
            a = cmd_address;
            for (int i = 0; i < int'(cmd_length); i++) begin
              mq.push_back(a);
              a = cmd_down ? 8'(a - STRIDE) : 8'(a + STRIDE);
            end
            nd = (cmd_length == 4'd0);
          end
        end else if (beat_ready) begin
          void'(mq.pop_front());
          nd = (mq.size() == 0);
        end
        mdone = nd;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
